// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and the control state enumeration.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

endpackage

// File: rtl/hilo_pair.sv
// HI/LO architectural registers. A completing multiply/divide write
// takes precedence over MTHI/MTLO strobes arriving on the same edge.
module hilo_pair
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fin_we_i,
    input  logic [WIDTH-1:0] fin_hi_i,
    input  logic [WIDTH-1:0] fin_lo_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fin_we_i) begin
            hi_q <= fin_hi_i;
            lo_q <= fin_lo_i;
        end else begin
            if (wr_hi_i) hi_q <= wdata_i;
            if (wr_lo_i) lo_q <= wdata_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per
// cycle on operand magnitudes, with sign fix-up applied on the final write.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q;
    logic               neg_q, rem_neg_q, dbz_q;
    logic               busy_q, done_q, dbz_pulse_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic               fin_we;

    assign a_neg = op_i[0] & a_i[WIDTH-1];
    assign b_neg = op_i[0] & b_i[WIDTH-1];
    assign mag_a = a_neg ? -a_i : a_i;
    assign mag_b = b_neg ? -b_i : b_i;

    // Multiply keeps {partial product, remaining multiplier bits} in acc_q;
    // divide shifts dividend bits out of acc_q's low half as quotient bits enter.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
        acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
        rem_d     = rem_q;
        if (is_div_q) begin
            if (!div_trial[WIDTH+1]) begin
                rem_d = div_trial[WIDTH:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = div_shift;
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            fin_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fin_hi = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
    end

    assign fin_we = (state_q == FINISH) && !cancel_i && !dbz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_div_q    <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        is_div_q  <= op_i[1];
                        opnd_q    <= op_i[1] ? mag_b : mag_a;
                        acc_q     <= {{WIDTH{1'b0}}, (op_i[1] ? mag_a : mag_b)};
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        dbz_q     <= op_i[1] && (b_i == '0);
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel_i) begin
                        done_q      <= 1'b1;
                        dbz_pulse_q <= dbz_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    hilo_pair #(.WIDTH(WIDTH)) u_hilo (
        .clk      (clk),
        .rst      (rst),
        .fin_we_i (fin_we),
        .fin_hi_i (fin_hi),
        .fin_lo_i (fin_lo),
        .wr_hi_i  (wr_hi_i),
        .wr_lo_i  (wr_lo_i),
        .wdata_i  (wdata_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_pulse_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: expected HI/LO/div-by-zero
// results are queued at issue and compared when done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         start  = 1'b0;
    logic [1:0]   op     = 2'b00;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         cancel = 1'b0;
    logic         wr_hi  = 1'b0;
    logic         wr_lo  = 1'b0;
    logic [W-1:0] wdata  = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] sh_hi    = '0;
    logic [W-1:0] sh_lo    = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .cancel_i      (cancel),
        .wr_hi_i       (wr_hi),
        .wr_lo_i       (wr_lo),
        .wdata_i       (wdata),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz),
        .hi_o          (hi),
        .lo_o          (lo)
    );

    always #5 clk = ~clk;

    // Reference behaviour from native 64-bit arithmetic; divide by zero keeps HI/LO.
    function automatic exp_t model(input logic [1:0] mop, input logic [W-1:0] ma,
                                   input logic [W-1:0] mb, input logic [W-1:0] cur_hi,
                                   input logic [W-1:0] cur_lo);
        exp_t        r;
        logic [63:0] p;
        longint      q, m;
        r = '0;
        case (mop)
            OP_MULTU: begin
                p = {32'b0, ma} * {32'b0, mb};
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            OP_MULT: begin
                p = longint'($signed(ma)) * longint'($signed(mb));
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            default: begin
                if (mb == '0) begin
                    r.hi = cur_hi; r.lo = cur_lo; r.dbz = 1'b1;
                end else if (mop == OP_DIVU) begin
                    r.lo = ma / mb; r.hi = ma % mb;
                end else begin
                    q = longint'($signed(ma)) / longint'($signed(mb));
                    m = longint'($signed(ma)) % longint'($signed(mb));
                    r.lo = q[31:0]; r.hi = m[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(negedge clk);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accept edge until done; busy must hold high until then.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = (busy === 1'b1);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (dbz !== 1'b0) $display("[TB] FAIL reset_dbz: got %b want 0", dbz); else n_pass++;
        n_checks++; if (hi !== '0) $display("[TB] FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== '0) $display("[TB] FAIL reset_lo: got %h want 0", lo); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu();
        int   lat;
        bit   bok;
        exp_t e;
        sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0});
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++; if (lat != 33) $display("[TB] FAIL multu_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (!bok) $display("[TB] FAIL multu_busy_window: got 0 want 1"); else n_pass++;
        n_checks++; if (hi !== e.hi) $display("[TB] FAIL multu_hi: got %h want %h", hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("[TB] FAIL multu_lo: got %h want %h", lo, e.lo); else n_pass++;
        n_checks++; if (dbz !== e.dbz) $display("[TB] FAIL multu_dbz: got %b want %b", dbz, e.dbz); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL multu_done_pulse: got %b want 0", done); else n_pass++;
        sh_hi = e.hi; sh_lo = e.lo;
    endtask

    task automatic test_signed();
        int           lat;
        bit           bok;
        exp_t         e;
        logic [1:0]   ops [3] = '{OP_MULT, OP_DIV, OP_DIVU};
        logic [W-1:0] as  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100};
        logic [W-1:0] bs  [3] = '{32'd7, 32'd2, 32'd7};
        exp_t         ex  [3] = '{'{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0},
                                  '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0},
                                  '{hi: 32'd2,         lo: 32'd14,        dbz: 1'b0}};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, bok);
            e = sb.pop_front();
            n_checks++; if (lat != 33) $display("[TB] FAIL signed%0d_latency: got %0d want 33", i, lat); else n_pass++;
            n_checks++; if (hi !== e.hi) $display("[TB] FAIL signed%0d_hi: got %h want %h", i, hi, e.hi); else n_pass++;
            n_checks++; if (lo !== e.lo) $display("[TB] FAIL signed%0d_lo: got %h want %h", i, lo, e.lo); else n_pass++;
            sh_hi = e.hi; sh_lo = e.lo;
        end
    endtask

    task automatic test_div_by_zero();
        int   lat;
        bit   bok;
        exp_t e;
        @(negedge clk); wr_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5678;
        @(negedge clk); wr_lo = 1'b0;
        n_checks++; if (hi !== 32'h1234) $display("[TB] FAIL mthi: got %h want 00001234", hi); else n_pass++;
        n_checks++; if (lo !== 32'h5678) $display("[TB] FAIL mtlo: got %h want 00005678", lo); else n_pass++;
        sb.push_back('{hi: 32'h1234, lo: 32'h5678, dbz: 1'b1});
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++; if (lat != 33) $display("[TB] FAIL dbz_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (dbz !== e.dbz) $display("[TB] FAIL dbz_flag: got %b want %b", dbz, e.dbz); else n_pass++;
        n_checks++; if (hi !== e.hi) $display("[TB] FAIL dbz_hi: got %h want %h", hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("[TB] FAIL dbz_lo: got %h want %h", lo, e.lo); else n_pass++;
        sh_hi = e.hi; sh_lo = e.lo;
    endtask

    task automatic test_corner();
        int   lat;
        bit   bok;
        exp_t e;
        sb.push_back('{hi: 32'h0, lo: 32'h8000_0000, dbz: 1'b0});
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++; if (hi !== e.hi) $display("[TB] FAIL divmin_hi: got %h want %h", hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("[TB] FAIL divmin_lo: got %h want %h", lo, e.lo); else n_pass++;
        sb.push_back('{hi: 32'h4000_0000, lo: 32'h0, dbz: 1'b0});
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++; if (hi !== e.hi) $display("[TB] FAIL multmin_hi: got %h want %h", hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("[TB] FAIL multmin_lo: got %h want %h", lo, e.lo); else n_pass++;
        sh_hi = e.hi; sh_lo = e.lo;
    endtask

    task automatic test_ignore_cancel();
        int   lat;
        bit   seen;
        exp_t e;
        sb.push_back('{hi: 32'h0, lo: 32'd15, dbz: 1'b0});
        issue(OP_MULTU, 32'd3, 32'd5);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFF; b = 32'd2;
            end
            @(posedge clk); #1 start = 1'b0;
            if (done === 1'b1) begin lat = k; break; end
        end
        e = sb.pop_front();
        n_checks++; if (lat != 33) $display("[TB] FAIL ignore_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (hi !== e.hi) $display("[TB] FAIL ignore_hi: got %h want %h", hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("[TB] FAIL ignore_lo: got %h want %h", lo, e.lo); else n_pass++;
        sh_hi = e.hi; sh_lo = e.lo;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL ignore_no_restart: got %b want 0", busy); else n_pass++;

        issue(OP_MULTU, 32'd11, 32'd13);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) cancel = 1'b1;
            @(posedge clk); #1;
        end
        cancel = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL cancel_busy: got %b want 0", busy); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen) $display("[TB] FAIL cancel_no_done: got 1 want 0"); else n_pass++;
        n_checks++; if (hi !== sh_hi) $display("[TB] FAIL cancel_hi: got %h want %h", hi, sh_hi); else n_pass++;
        n_checks++; if (lo !== sh_lo) $display("[TB] FAIL cancel_lo: got %h want %h", lo, sh_lo); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        issue(OP_MULTU, 32'd1000, 32'd1000);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL rstmid_done: got %b want 0", done); else n_pass++;
        n_checks++; if (hi !== '0) $display("[TB] FAIL rstmid_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== '0) $display("[TB] FAIL rstmid_lo: got %h want 0", lo); else n_pass++;
        @(negedge clk); rst = 1'b0;
        sh_hi = '0; sh_lo = '0;
    endtask

    task automatic test_wr_on_finish();
        int   lat;
        exp_t e;
        sb.push_back('{hi: 32'h0, lo: 32'd42, dbz: 1'b0});
        issue(OP_MULTU, 32'd6, 32'd7);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 33) begin
                wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            wr_hi = 1'b0; wr_lo = 1'b0;
            if (done === 1'b1) begin lat = k; break; end
        end
        e = sb.pop_front();
        n_checks++; if (lat != 33) $display("[TB] FAIL wrfin_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (hi !== e.hi) $display("[TB] FAIL wrfin_hi: got %h want %h", hi, e.hi); else n_pass++;
        n_checks++; if (lo !== e.lo) $display("[TB] FAIL wrfin_lo: got %h want %h", lo, e.lo); else n_pass++;
        sh_hi = e.hi; sh_lo = e.lo;
    endtask

    task automatic test_back_to_back();
        int           lat;
        bit           bok;
        exp_t         e;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 8; i++) begin
            rop = 2'(i % 4);
            ra  = $urandom;
            rb  = (i == 6) ? '0 : $urandom;
            e   = model(rop, ra, rb, sh_hi, sh_lo);
            sb.push_back(e);
            issue(rop, ra, rb);
            wait_done(lat, bok);
            e = sb.pop_front();
            n_checks++; if (lat != 33) $display("[TB] FAIL b2b%0d_latency: got %0d want 33", i, lat); else n_pass++;
            n_checks++; if (hi !== e.hi) $display("[TB] FAIL b2b%0d_hi: op %0d a %h b %h got %h want %h", i, rop, ra, rb, hi, e.hi); else n_pass++;
            n_checks++; if (lo !== e.lo) $display("[TB] FAIL b2b%0d_lo: op %0d a %h b %h got %h want %h", i, rop, ra, rb, lo, e.lo); else n_pass++;
            n_checks++; if (dbz !== e.dbz) $display("[TB] FAIL b2b%0d_dbz: got %b want %b", i, dbz, e.dbz); else n_pass++;
            sh_hi = e.hi; sh_lo = e.lo;
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_by_zero();
        test_corner();
        test_ignore_cancel();
        test_reset_mid_run();
        test_wr_on_finish();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
